csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 183 ++++++++++++++++++
 tb/tb_csr_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with trap/mret sequencing; 64-bit mcycle/minstret built only with CSR_COUNTERS_EN.
// Latency: reads combinational, updates on the next rising edge; no backpressure, every access completes in its cycle.
module csr_unit #(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_ret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_req_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic        mip_meip, mip_mtip;

  logic [31:0] mstatus_val, mip_val;
  logic [31:0] rdata, wval;
  logic        addr_known, addr_ro, access, nz_write, illegal, we;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`else
  logic        unused_instr_ret;
  assign unused_instr_ret = instr_ret_i;
`endif

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mip_val     = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};

  always_comb begin
    rdata      = 32'h0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr_i)
      ADDR_MSTATUS:  rdata = mstatus_val;
      ADDR_MISA:     begin rdata = MISA_VAL; addr_ro = 1'b1; end
      ADDR_MIE:      rdata = mie_q;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MTVAL:    rdata = mtval_q;
      ADDR_MIP:      rdata = mip_val;
      ADDR_MHARTID:  begin rdata = HART_ID; addr_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH: rdata = minstret_q[63:32];
`else
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: rdata = 32'h0;
`endif
      default:       addr_known = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read: never faults, never writes
  assign access   = (csr_op_i != OP_NONE);
  assign nz_write = (csr_op_i == OP_WRITE) || (csr_wdata_i != 32'h0);
  assign illegal  = access && nz_write && (!addr_known || addr_ro);
  assign we       = access && nz_write && !illegal;

  always_comb begin
    wval = csr_wdata_i;
    if (csr_op_i == OP_SET)
      wval = rdata | csr_wdata_i;
    else if (csr_op_i != OP_WRITE)
      wval = rdata & ~csr_wdata_i;
  end

  // CSR writes first; trap and mret assignments later in the block override them
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= 32'h0;
      mtvec_q      <= MTVEC_RST & ALIGN_MASK;
      mscratch_q   <= 32'h0;
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
      mtval_q      <= 32'h0;
      mip_meip     <= 1'b0;
      mip_mtip     <= 1'b0;
    end else begin
      mip_meip <= irq_ext_i;
      mip_mtip <= irq_timer_i;
      if (we) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          ADDR_MIE:      mie_q      <= wval & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= wval & ALIGN_MASK;
          ADDR_MSCRATCH: mscratch_q <= wval;
          ADDR_MEPC:     mepc_q     <= wval & ALIGN_MASK;
          ADDR_MCAUSE:   mcause_q   <= wval;
          ADDR_MTVAL:    mtval_q    <= wval;
          default: ;
        endcase
      end
      if (trap_i) begin
        mepc_q       <= trap_pc_i & ALIGN_MASK;
        mcause_q     <= trap_cause_i;
        mtval_q      <= trap_val_i;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // a write to one half freezes the other half for that cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (we && csr_addr_i == ADDR_MCYCLE)
        mcycle_q[31:0] <= wval;
      else if (we && csr_addr_i == ADDR_MCYCLEH)
        mcycle_q[63:32] <= wval;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (we && csr_addr_i == ADDR_MINSTRET)
        minstret_q[31:0] <= wval;
      else if (we && csr_addr_i == ADDR_MINSTRETH)
        minstret_q[63:32] <= wval;
      else if (instr_ret_i)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`endif

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = illegal;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_req_o     = mstatus_mie & (|(mie_q & mip_val));

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: vector table through an expected-value queue, plus trap/irq/reset/counter sequences.
module tb_csr_unit;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        instr_ret, trap, mret, irq_ext, irq_timer, irq_req;
  logic [31:0] trap_pc, trap_cause, trap_val, mtvec, mepc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  vec_t vecs[27];
  exp_t exp_q[$];

  csr_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .csr_addr_i   (csr_addr),
    .csr_op_i     (csr_op),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .csr_illegal_o(csr_illegal),
    .instr_ret_i  (instr_ret),
    .trap_i       (trap),
    .trap_pc_i    (trap_pc),
    .trap_cause_i (trap_cause),
    .trap_val_i   (trap_val),
    .mret_i       (mret),
    .irq_ext_i    (irq_ext),
    .irq_timer_i  (irq_timer),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc),
    .irq_req_o    (irq_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one-cycle read with no access, sampled at the falling edge
  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    csr_addr = a;
    csr_op   = 2'b00;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic access(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    @(posedge clk);
    #1;
    csr_addr  = a;
    csr_op    = o;
    csr_wdata = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;

    vecs[0]  = '{A_MSTATUS,  2'b00, 32'h0,          32'h0000_1800, 1'b0};
    vecs[1]  = '{A_MSTATUS,  2'b01, 32'hFFFF_FFFF,  32'h0000_1800, 1'b0};
    vecs[2]  = '{A_MSTATUS,  2'b00, 32'h0,          32'h0000_1888, 1'b0};
    vecs[3]  = '{A_MSTATUS,  2'b11, 32'h0000_0080,  32'h0000_1888, 1'b0};
    vecs[4]  = '{A_MSTATUS,  2'b00, 32'h0,          32'h0000_1808, 1'b0};
    vecs[5]  = '{A_MISA,     2'b01, 32'h0,          32'h4000_0100, 1'b1};
    vecs[6]  = '{A_MISA,     2'b00, 32'h0,          32'h4000_0100, 1'b0};
    vecs[7]  = '{A_MISA,     2'b10, 32'h0,          32'h4000_0100, 1'b0};
    vecs[8]  = '{12'h7C0,    2'b01, 32'h1,          32'h0,         1'b1};
    vecs[9]  = '{A_MHARTID,  2'b01, 32'h5,          32'h0,         1'b1};
    vecs[10] = '{A_MHARTID,  2'b00, 32'h0,          32'h0,         1'b0};
    vecs[11] = '{A_MTVEC,    2'b01, 32'h0000_1237,  32'h0,         1'b0};
    vecs[12] = '{A_MTVEC,    2'b00, 32'h0,          32'h0000_1234, 1'b0};
    vecs[13] = '{A_MIE,      2'b01, 32'hFFFF_FFFF,  32'h0,         1'b0};
    vecs[14] = '{A_MIE,      2'b00, 32'h0,          32'h0000_0888, 1'b0};
    vecs[15] = '{A_MSCRATCH, 2'b01, 32'hA5A5_A5A5,  32'h0,         1'b0};
    vecs[16] = '{A_MSCRATCH, 2'b10, 32'h0F0F_0000,  32'hA5A5_A5A5, 1'b0};
    vecs[17] = '{A_MSCRATCH, 2'b11, 32'h0000_00A5,  32'hAFAF_A5A5, 1'b0};
    vecs[18] = '{A_MSCRATCH, 2'b00, 32'h0,          32'hAFAF_A500, 1'b0};
    vecs[19] = '{A_MIP,      2'b01, 32'hFFFF_FFFF,  32'h0,         1'b0};
    vecs[20] = '{A_MIP,      2'b00, 32'h0,          32'h0,         1'b0};
    vecs[21] = '{A_MEPC,     2'b01, 32'h0000_0203,  32'h0,         1'b0};
    vecs[22] = '{A_MEPC,     2'b00, 32'h0,          32'h0000_0200, 1'b0};
    vecs[23] = '{A_MIE,      2'b11, 32'h0000_0088,  32'h0000_0888, 1'b0};
    vecs[24] = '{12'h7C0,    2'b00, 32'h0,          32'h0,         1'b0};
    vecs[25] = '{A_MCAUSE,   2'b00, 32'h0,          32'h0,         1'b0};
    vecs[26] = '{A_MIE,      2'b00, 32'h0,          32'h0000_0800, 1'b0};

    rst_ni = 1'b0; csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 32'h0;
    instr_ret = 1'b0; trap = 1'b0; mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
    trap_pc = 32'h0; trap_cause = 32'h0; trap_val = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // reset state
    rd(A_MSTATUS, 32'h0000_1800, "rst_mstatus");
    chk("rst_illegal", {31'b0, csr_illegal}, 32'h0);
    chk("rst_irq", {31'b0, irq_req}, 32'h0);
    chk("rst_mepc_o", mepc, 32'h0);
    chk("rst_mtvec_o", mtvec, 32'h0);
    rd(A_MISA, 32'h4000_0100, "rst_misa");
    rd(A_MSCRATCH, 32'h0, "rst_mscratch");

    // vector table
    for (int i = 0; i < 27; i++) begin
      access(vecs[i].addr, vecs[i].op, vecs[i].wdata);
      exp_q.push_back('{i, vecs[i].exp_rdata, vecs[i].exp_ill});
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_rdata", e.idx), csr_rdata, e.rdata);
      chk($sformatf("vec%0d_illegal", e.idx), {31'b0, csr_illegal}, {31'b0, e.ill});
    end
    @(posedge clk); #1 csr_op = 2'b00;
    chk("mtvec_o", mtvec, 32'h0000_1234);

    // external interrupt: MIE=1, mie=0x800
    irq_ext = 1'b1;
    @(negedge clk);
    chk("irq_before_mip", {31'b0, irq_req}, 32'h0);
    @(negedge clk);
    chk("irq_after_mip", {31'b0, irq_req}, 32'h1);

    // trap with a competing mepc write in the same cycle
    @(posedge clk); #1;
    trap = 1'b1; trap_pc = 32'h0000_0102; trap_cause = 32'h8000_000B; trap_val = 32'h0000_DEAD;
    csr_addr = A_MEPC; csr_op = 2'b01; csr_wdata = 32'h4;
    @(posedge clk); #1;
    trap = 1'b0; csr_op = 2'b00;
    @(negedge clk);
    chk("trap_mepc_o", mepc, 32'h0000_0100);
    chk("trap_irq", {31'b0, irq_req}, 32'h0);
    rd(A_MSTATUS, 32'h0000_1880, "trap_mstatus");
    rd(A_MCAUSE, 32'h8000_000B, "trap_mcause");
    rd(A_MTVAL, 32'h0000_DEAD, "trap_mtval");

    // mret restores MIE
    @(posedge clk); #1 mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    rd(A_MSTATUS, 32'h0000_1888, "mret_mstatus");
    chk("mret_irq", {31'b0, irq_req}, 32'h1);

    // trap and mret together: trap wins
    @(posedge clk); #1;
    trap = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0303;
    @(posedge clk); #1;
    trap = 1'b0; mret = 1'b0;
    rd(A_MSTATUS, 32'h0000_1880, "trapmret_mstatus");
    chk("trapmret_mepc_o", mepc, 32'h0000_0300);
    chk("trapmret_irq", {31'b0, irq_req}, 32'h0);
    irq_ext = 1'b0;

`ifdef CSR_COUNTERS_EN
    // mcycle carry into mcycleh
    access(A_MCYCLE, 2'b01, 32'hFFFF_FFFE);
    access(A_MCYCLEH, 2'b01, 32'h0);
    @(posedge clk); #1 csr_op = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    csr_addr = A_MCYCLEH; #1;
    chk("mcycleh_carry", csr_rdata, 32'h1);
    csr_addr = A_MCYCLE; #1;
    chk("mcycle_wrap", csr_rdata, 32'h0);

    // minstret counts retired instructions only
    access(A_MINSTRET, 2'b01, 32'h0);
    @(posedge clk); #1 csr_op = 2'b00; instr_ret = 1'b1;
    repeat (3) @(posedge clk);
    #1 instr_ret = 1'b0;
    rd(A_MINSTRET, 32'h3, "minstret_count");
    rd(A_MINSTRETH, 32'h0, "minstreth_hold");
`else
    access(A_MCYCLE, 2'b01, 32'h1234);
    @(negedge clk);
    chk("mcycle_wr_illegal", {31'b0, csr_illegal}, 32'h0);
    @(posedge clk); #1 csr_op = 2'b00;
    rd(A_MCYCLE, 32'h0, "mcycle_absent");
    rd(A_MINSTRETH, 32'h0, "minstreth_absent");
`endif

    // reset discards an in-flight write
    @(posedge clk); #1;
    rst_ni = 1'b0; csr_addr = A_MSCRATCH; csr_op = 2'b01; csr_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst_ni = 1'b1; csr_op = 2'b00;
    rd(A_MSCRATCH, 32'h0, "rst2_mscratch");
    rd(A_MSTATUS, 32'h0000_1800, "rst2_mstatus");
    chk("rst2_mtvec_o", mtvec, 32'h0);
    chk("rst2_mepc_o", mepc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
